// File: rtl/fetch.sv
// fetch: memory-read master for the ForthSuper byte-wide memory block.
// Reads one CSZ-bit cell from NB consecutive byte addresses, starting at ai,
// and assembles it big-endian (the byte at ai lands in the MSBs).
// The memory is a registered RAM, so each byte appears on mem_vo one cycle
// after its address; capture therefore trails the address pointer by one cycle.
// Optional build macro FETCH_BYTE_EN adds input bw for single-byte fetches
// (C@), zero-extended into vo.
module fetch #(
  parameter int DSZ = 8,
  parameter int ASZ = 17,
  parameter int CSZ = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic [ASZ-1:0] ai,
`ifdef FETCH_BYTE_EN
  input  logic           bw,
`endif
  output logic           bsy,
  output logic           vld,
  output logic [CSZ-1:0] vo,
  output logic [ASZ-1:0] mem_ai,
  output logic           mem_we,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo
);

  localparam int NB = CSZ / DSZ;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] NB_C = CW'(NB);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RD   = 1'b1
  } state_t;

  state_t         r_state, w_state_nx;
  logic [ASZ-1:0] r_ptr,   w_ptr_nx;
  logic [CW-1:0]  r_cnt,   w_cnt_nx;
  logic [CSZ-1:0] r_acc,   w_acc_nx;
  logic [CSZ-1:0] r_vo,    w_vo_nx;
  logic           r_vld,   w_vld_nx;
  logic           r_bsy,   w_bsy_nx;
  logic           w_last;
  logic [CSZ-1:0] w_cell;

`ifdef FETCH_BYTE_EN
  logic r_bw, w_bw_nx;
  // A byte fetch finishes after its single byte has been captured.
  assign w_last = r_bw ? (r_cnt == CW'(1)) : (r_cnt == NB_C);
  assign w_cell = r_bw ? {{(CSZ-DSZ){1'b0}}, mem_vo}
                       : {r_acc[CSZ-DSZ-1:0], mem_vo};
`else
  assign w_last = (r_cnt == NB_C);
  assign w_cell = {r_acc[CSZ-DSZ-1:0], mem_vo};
`endif

  // Next-state and datapath update; vld defaults low so it can only pulse.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    w_vo_nx    = r_vo;
    w_vld_nx   = 1'b0;
    w_bsy_nx   = r_bsy;
`ifdef FETCH_BYTE_EN
    w_bw_nx    = r_bw;
`endif
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_ptr_nx   = ai;
          w_cnt_nx   = '0;
          w_acc_nx   = '0;
          w_bsy_nx   = 1'b1;
          w_state_nx = S_RD;
`ifdef FETCH_BYTE_EN
          w_bw_nx    = bw;
`endif
        end
      end
      S_RD: begin
        // Pointer stops advancing once every byte address has been issued.
        if (r_cnt < NB_C) w_ptr_nx = r_ptr + ASZ'(1);
        // First cycle has no data yet: RAM output lags its address by one.
        if (r_cnt != '0) w_acc_nx = {r_acc[CSZ-DSZ-1:0], mem_vo};
        w_cnt_nx = r_cnt + CW'(1);
        if (w_last) begin
          w_vo_nx    = w_cell;
          w_vld_nx   = 1'b1;
          w_bsy_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register; reset discards any partial cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_vo  <= '0;
      r_vld <= 1'b0;
      r_bsy <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nx;
      r_cnt <= w_cnt_nx;
      r_acc <= w_acc_nx;
      r_vo  <= w_vo_nx;
      r_vld <= w_vld_nx;
      r_bsy <= w_bsy_nx;
    end
  end

`ifdef FETCH_BYTE_EN
  // Byte-width flag captured with the start address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bw <= 1'b0;
    else        r_bw <= w_bw_nx;
  end
`endif

  assign bsy    = r_bsy;
  assign vld    = r_vld;
  assign vo     = r_vo;
  assign mem_ai = r_ptr;
  assign mem_we = 1'b0;
  assign mem_vi = '0;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for fetch with a registered byte-RAM model.
// Expected cells are queued when a fetch is issued; a negedge monitor pops
// and compares them whenever vld is seen.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [16:0] ai;
  logic        bw;
  logic        bsy;
  logic        vld;
  logic [31:0] vo;
  logic [16:0] mem_ai;
  logic        mem_we;
  logic [7:0]  mem_vi;
  logic [7:0]  mem_vo;

  logic [7:0]  mem [0:(1<<17)-1];
  logic [31:0] exp_q[$];
  int          n_chk;
  int          n_fail;
  logic        prev_vld;

  fetch #(.DSZ(8), .ASZ(17), .CSZ(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .ai     (ai),
`ifdef FETCH_BYTE_EN
    .bw     (bw),
`endif
    .bsy    (bsy),
    .vld    (vld),
    .vo     (vo),
    .mem_ai (mem_ai),
    .mem_we (mem_we),
    .mem_vi (mem_vi),
    .mem_vo (mem_vo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered RAM: data for an address appears the cycle after it.
  always @(posedge clk) mem_vo <= mem[mem_ai];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      check("vld_not_back_to_back", {31'b0, prev_vld}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 32'd1, 32'd0);
      end else begin
        check("vo", vo, exp_q.pop_front());
      end
    end
    prev_vld = vld;
  end

  // Issue one fetch from IDLE, follow its address sequence and latency.
  task automatic run_fetch(input logic [16:0] a, input logic [31:0] exp,
                           input logic b, input int lat);
    bit  done;
    int  n_addr;
    logic [16:0] ea;
    n_addr = b ? 1 : 4;
    @(negedge clk);
    req = 1'b1; ai = a; bw = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 req = 1'b0;
    done = 0;
    for (int k = 1; k <= lat + 6 && !done; k++) begin
      @(negedge clk);
      if (k <= n_addr) begin
        ea = a + 17'(k - 1);
        check("mem_ai_seq", {15'b0, mem_ai}, {15'b0, ea});
      end
      if (vld === 1'b1) begin
        check("latency_edges", k - 1, lat);
        check("bsy_at_vld", {31'b0, bsy}, 32'd0);
        done = 1;
      end else begin
        check("bsy_during", {31'b0, bsy}, 32'd1);
      end
    end
    if (!done) check("vld_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t_first;
    bit seen;
    n_chk = 0; n_fail = 0; prev_vld = 1'b0;
    for (int i = 0; i < (1<<17); i++) mem[i] = 8'h00;
    mem[17'h100] = 8'h12; mem[17'h101] = 8'h34;
    mem[17'h102] = 8'h56; mem[17'h103] = 8'h78; mem[17'h104] = 8'h9A;
    mem[17'h1FFFE] = 8'hAA; mem[17'h1FFFF] = 8'hBB;
    mem[17'h00000] = 8'hCC; mem[17'h00001] = 8'hDD;
    mem[17'h200] = 8'h01; mem[17'h201] = 8'h02; mem[17'h202] = 8'h03; mem[17'h203] = 8'h04;
    mem[17'h204] = 8'h05; mem[17'h205] = 8'h06; mem[17'h206] = 8'h07; mem[17'h207] = 8'h08;
    req = 1'b0; ai = '0; bw = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_bsy", {31'b0, bsy}, 32'd0);
    check("rst_vld", {31'b0, vld}, 32'd0);
    check("rst_vo", vo, 32'd0);
    check("rst_mem_ai", {15'b0, mem_ai}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_vi", {24'b0, mem_vi}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic cell fetch: 4 addresses, vld 5 edges after acceptance.
    run_fetch(17'h100, 32'h12345678, 1'b0, 5);
    check("mem_we_op", {31'b0, mem_we}, 32'd0);
    check("mem_vi_op", {24'b0, mem_vi}, 32'd0);

    // Address wrap-around.
    run_fetch(17'h1FFFE, 32'hAABBCCDD, 1'b0, 5);

    // req held high: second fetch accepted on the edge right after vld.
    @(negedge clk);
    req = 1'b1; ai = 17'h200;
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h05060708);
    seen = 0; t_first = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (vld === 1'b1) seen = 1;
    end
    if (!seen) check("b2b_first_timeout", 32'd1, 32'd0);
    ai = 17'h204;
    @(negedge clk);
    check("b2b_vld_after", {31'b0, vld}, 32'd0);
    check("b2b_bsy_after", {31'b0, bsy}, 32'd1);
    seen = 0;
    // Accept edge plus 5 completion edges: next vld 6 cycles after the first.
    for (int k = 2; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        seen = 1;
        check("b2b_spacing", k, 6);
      end
    end
    if (!seen) check("b2b_second_timeout", 32'd1, 32'd0);
    req = 1'b0;
    repeat (3) @(negedge clk);

    // req during a fetch is ignored.
    @(negedge clk);
    req = 1'b1; ai = 17'h100;
    exp_q.push_back(32'h12345678);
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    req = 1'b1; ai = 17'h300;
    @(negedge clk);
    req = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_req_q", exp_q.size(), 32'd0);
    check("ignored_req_bsy", {31'b0, bsy}, 32'd0);

    // Async reset at cnt==2 kills the fetch.
    @(negedge clk);
    req = 1'b1; ai = 17'h100;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_bsy", {31'b0, bsy}, 32'd0);
    check("arst_vld", {31'b0, vld}, 32'd0);
    check("arst_vo", vo, 32'd0);
    check("arst_mem_ai", {15'b0, mem_ai}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_vo_hold", vo, 32'd0);
    run_fetch(17'h100, 32'h12345678, 1'b0, 5);

`ifdef FETCH_BYTE_EN
    run_fetch(17'h101, 32'h00000034, 1'b1, 2);
    run_fetch(17'h101, 32'h3456789A, 1'b0, 5);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
